// File: rtl/conv_row_feeder.sv
// -----------------------------------------------------------------------------
// conv_row_feeder
//
// Purpose
//   Source side of the conv_top row interface. A raster pixel stream is written
//   into a 4-slot line buffer. For each output row r, a zero-padded 3-row window
//   (rows r-1, r and r+1) is presented on image0_o/image1_o/image2_o. The window
//   is announced with a one-cycle image_start_o pulse. The block then waits for
//   image_done_i before it moves to the next window. One frame is H windows,
//   followed by a one-cycle frame_done_o pulse.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rstn_i         synchronous reset, active-high despite its name
//   pix_data_i     one pixel; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   pix_valid_i    pixel valid
//   pix_ready_o    pixel accepted when valid & ready
//   image0_o       window top row    (padded row r-1, zero for r==0)
//   image1_o       window middle row (padded row r)
//   image2_o       window bottom row (padded row r+1, zero for r==H-1)
//   image_start_o  one-cycle pulse: the window on image*_o is valid
//   image_done_i   one-cycle pulse from conv_top: the window has been consumed
//   frame_done_o   one-cycle pulse after the last window of the frame is done
//
// Row packing: channel c, padded column p sits at
//   [(c*(W+2)+p)*DATA_WIDTH +: DATA_WIDTH]. Columns p=0 and p=W+1 are zero.
//   Pixel column x maps to p=x+1.
// -----------------------------------------------------------------------------
module conv_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int D          = 4,
  parameter int W          = 12,
  parameter int H          = 12
) (
  input  logic                            clk,
  input  logic                            rstn_i,
  input  logic [D*DATA_WIDTH-1:0]         pix_data_i,
  input  logic                            pix_valid_i,
  output logic                            pix_ready_o,
  output logic [D*(W+2)*DATA_WIDTH-1:0]   image0_o,
  output logic [D*(W+2)*DATA_WIDTH-1:0]   image1_o,
  output logic [D*(W+2)*DATA_WIDTH-1:0]   image2_o,
  output logic                            image_start_o,
  input  logic                            image_done_i,
  output logic                            frame_done_o
);

  localparam int ROW_BITS = D*(W+2)*DATA_WIDTH;
  localparam int PIX_BITS = D*DATA_WIDTH;
  // The row and window counters share one width. It must hold values up to H+2.
  localparam int CNT_W    = $clog2(H+3);
  localparam int COL_W    = (W > 1) ? $clog2(W) : 1;

  localparam logic [CNT_W-1:0] C_H        = CNT_W'(H);
  localparam logic [CNT_W-1:0] C_H_M1     = CNT_W'(H-1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(W-1);
  localparam logic [COL_W-1:0] C_COL_ONE  = COL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_FDONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]    r_rows_in;
  logic [CNT_W-1:0]    r_win;
  logic [COL_W-1:0]    r_col;
  logic [PIX_BITS-1:0] r_lbuf [4][W];
  logic [ROW_BITS-1:0] r_img0;
  logic [ROW_BITS-1:0] r_img1;
  logic [ROW_BITS-1:0] r_img2;

  logic                w_push;
  logic                w_row_last;
  logic                w_load;
  logic                w_win_inc;
  logic                w_frame_clr;
  logic [CNT_W-1:0]    w_win_p2;
  logic [CNT_W-1:0]    w_need;
  logic [1:0]          w_slot_top;
  logic [1:0]          w_slot_mid;
  logic [1:0]          w_slot_bot;
  logic [ROW_BITS-1:0] w_row_top;
  logic [ROW_BITS-1:0] w_row_mid;
  logic [ROW_BITS-1:0] w_row_bot;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  assign w_win_p2 = r_win + C_TWO;
  // A window needs rows up to win+1. The last window needs every row of the frame.
  assign w_need   = (w_win_p2 > C_H) ? C_H : w_win_p2;

  // Accepting up to row win+2 lets one row fill while conv runs. With 4 slots,
  // the row being written never lands on rows win-1..win+1.
  // Reset gates ready so that no handshake is offered while reset is held.
  assign pix_ready_o = !rstn_i && (r_rows_in < C_H) && (r_rows_in <= w_win_p2);
  assign w_push      = pix_valid_i && pix_ready_o;
  assign w_row_last  = (r_col == C_COL_LAST);

  // The line buffer holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lbuf[r_rows_in[1:0]][r_col] <= pix_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Window assembly: slot rotation is row index mod 4
  // ---------------------------------------------------------------------------
  assign w_slot_mid = r_win[1:0];
  assign w_slot_top = r_win[1:0] - 2'd1;
  assign w_slot_bot = r_win[1:0] + 2'd1;

  for (genvar gi = 0; gi < D; gi++) begin : g_chan
    for (genvar gj = 0; gj < W+2; gj++) begin : g_col
      localparam int LSB = (gi*(W+2)+gj)*DATA_WIDTH;
      if (gj == 0 || gj == W+1) begin : g_pad
        assign w_row_top[LSB +: DATA_WIDTH] = '0;
        assign w_row_mid[LSB +: DATA_WIDTH] = '0;
        assign w_row_bot[LSB +: DATA_WIDTH] = '0;
      end else begin : g_pix
        assign w_row_top[LSB +: DATA_WIDTH] = r_lbuf[w_slot_top][gj-1][gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_row_mid[LSB +: DATA_WIDTH] = r_lbuf[w_slot_mid][gj-1][gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_row_bot[LSB +: DATA_WIDTH] = r_lbuf[w_slot_bot][gj-1][gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_win_inc    = 1'b0;
    w_frame_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_rows_in >= w_need) begin
          // The window registers load on this edge, so they are valid
          // in the same cycle as the start pulse.
          w_load       = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (image_done_i) begin
          if (r_win == C_H_M1) begin
            w_state_next = S_FDONE;
          end else begin
            w_win_inc    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_FDONE: begin
        w_frame_clr  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The window advance and the row fill are independent. A done pulse and a
  // row's last pixel in the same cycle both take effect.
  always_ff @(posedge clk) begin
    if (rstn_i) begin
      r_state   <= S_IDLE;
      r_rows_in <= '0;
      r_win     <= '0;
      r_col     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_frame_clr) begin
        r_rows_in <= '0;
        r_win     <= '0;
        r_col     <= '0;
      end else begin
        if (w_push) begin
          if (w_row_last) begin
            r_col     <= '0;
            r_rows_in <= r_rows_in + C_ONE;
          end else begin
            r_col <= r_col + C_COL_ONE;
          end
        end
        if (w_win_inc) begin
          r_win <= r_win + C_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn_i) begin
      r_img0 <= '0;
      r_img1 <= '0;
      r_img2 <= '0;
    end else if (w_load) begin
      r_img0 <= (r_win == '0)    ? '0 : w_row_top;
      r_img1 <= w_row_mid;
      r_img2 <= (r_win == C_H_M1) ? '0 : w_row_bot;
    end
  end

  assign image0_o      = r_img0;
  assign image1_o      = r_img1;
  assign image2_o      = r_img2;
  assign image_start_o = (r_state == S_START);
  assign frame_done_o  = (r_state == S_FDONE);

endmodule
